// File: rtl/prefetch_queue.sv
// prefetch_queue: owns the fetch PC, runs one fetch read at a time, buffers words+PCs for decode.
// Latency: request 1 cycle after idle with credit; head valid 1 cycle after i_fetch_ack.
// Backpressure: no new fetch unless (count + in_flight) < DEPTH; i_stall only blocks issue. Option macro: PREFETCH_ALIGN_CHECK_EN.

module pq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head_dat
);
    localparam int AB = $clog2(DEPTH);

    logic [AB:0]   wr_ptr;
    logic [AB:0]   rd_ptr;
    logic [AB-1:0] wr_idx;
    logic [W-1:0]  mem [DEPTH];

    // A clear with a simultaneous push leaves exactly that one entry at slot 0.
    assign wr_idx   = clr ? '0 : wr_ptr[AB-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign head_dat = mem[rd_ptr[AB-1:0]];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            if (clr) begin
                rd_ptr <= '0;
                wr_ptr <= {{AB{1'b0}}, push};
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) mem[wr_idx] <= push_dat;
        end
    end
endmodule

module prefetch_queue #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_stall,
    input  logic          i_flush,
    input  logic [AW-1:0] i_flush_pc,
    output logic          o_fetch_read,
    output logic [AW-1:0] o_fetch_addr,
    input  logic [DW-1:0] i_fetch_data,
    input  logic          i_fetch_ack,
    output logic [DW-1:0] o_inst,
    output logic [AW-1:0] o_inst_pc,
    output logic          o_inst_valid,
`ifdef PREFETCH_ALIGN_CHECK_EN
    output logic          o_inst_misalign,
`endif
    input  logic          i_inst_ready
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    typedef struct packed {
`ifdef PREFETCH_ALIGN_CHECK_EN
        logic          misalign;
`endif
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } entry_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]          req_addr_q, req_addr_d;
    logic                   halt_q, halt_d;
    logic                   push, pop, empty, credit, in_flight;
    logic                   flush_misalign;
    logic [AW-1:0]          flush_target;
    logic [$clog2(DEPTH):0] count;
    entry_t                 push_ent, head_ent;

`ifdef PREFETCH_ALIGN_CHECK_EN
    assign flush_misalign = i_flush && (i_flush_pc[1:0] != 2'b00);
    assign flush_target   = i_flush_pc;
`else
    assign flush_misalign = 1'b0;
    assign flush_target   = i_flush_pc & ~AW'(3);
`endif

    assign in_flight = (state_q != S_IDLE);
    assign credit    = (int'(count) + (in_flight ? 1 : 0)) < DEPTH;
    assign pop       = !empty && i_inst_ready && !i_flush;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_addr_d    = req_addr_q;
        halt_d        = halt_q;
        push          = 1'b0;
        push_ent      = '0;
        push_ent.pc   = fetch_pc_q;
        push_ent.inst = i_fetch_data;

        case (state_q)
            S_IDLE: begin
                if (!i_flush && credit && !i_stall && !halt_q) begin
                    state_d    = S_REQ;
                    req_addr_d = fetch_pc_q;
                end
            end
            S_REQ: begin
                if (i_fetch_ack) begin
                    state_d = S_IDLE;
                    if (!i_flush) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + AW'(4);
                    end
                end else if (i_flush) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (i_fetch_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides the sequential PC; the outstanding read keeps its own address.
        if (i_flush) begin
            fetch_pc_d = flush_target;
            halt_d     = flush_misalign;
            if (flush_misalign) begin
                push        = 1'b1;
                push_ent    = '0;
                push_ent.pc = i_flush_pc;
`ifdef PREFETCH_ALIGN_CHECK_EN
                push_ent.misalign = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            halt_q     <= 1'b0;
        end else if (i_clk_en) begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            halt_q     <= halt_d;
        end
    end

    pq_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .en       (i_clk_en),
        .clr      (i_flush),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .empty    (empty),
        .count    (count),
        .head_dat (head_ent)
    );

    assign o_fetch_read = in_flight;
    assign o_fetch_addr = req_addr_q;
    assign o_inst_valid = !empty;
    assign o_inst       = head_ent.inst;
    assign o_inst_pc    = head_ent.pc;
`ifdef PREFETCH_ALIGN_CHECK_EN
    assign o_inst_misalign = head_ent.misalign;
`endif
endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: modelled arbiter with scoreboard of expected {inst, pc}, redirect vector table,
// and directed sequences for reset, backpressure, stall, clock-enable freeze and repeated flush.
module tb_prefetch_queue;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          i_clk        = 1'b0;
    logic          i_rst        = 1'b0;
    logic          i_clk_en     = 1'b1;
    logic          i_stall      = 1'b0;
    logic          i_flush      = 1'b0;
    logic [AW-1:0] i_flush_pc   = '0;
    logic [DW-1:0] i_fetch_data = '0;
    logic          i_fetch_ack  = 1'b0;
    logic          i_inst_ready = 1'b0;
    logic          o_fetch_read;
    logic [AW-1:0] o_fetch_addr;
    logic [DW-1:0] o_inst;
    logic [AW-1:0] o_inst_pc;
    logic          o_inst_valid;
`ifdef PREFETCH_ALIGN_CHECK_EN
    logic          o_inst_misalign;
`endif

    always #5 i_clk = ~i_clk;

    prefetch_queue dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clk_en     (i_clk_en),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_flush_pc   (i_flush_pc),
        .o_fetch_read (o_fetch_read),
        .o_fetch_addr (o_fetch_addr),
        .i_fetch_data (i_fetch_data),
        .i_fetch_ack  (i_fetch_ack),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_inst_valid (o_inst_valid),
`ifdef PREFETCH_ALIGN_CHECK_EN
        .o_inst_misalign (o_inst_misalign),
`endif
        .i_inst_ready (i_inst_ready)
    );

    typedef struct packed {
        logic [DW-1:0] inst;
        logic [AW-1:0] pc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] pc;
        int            lat;
        int            flush_at;
        logic [AW-1:0] exp_addr;
    } vec_t;

    exp_t          sbq[$];
    logic [AW-1:0] exp_pc    = '0;
    logic [AW-1:0] disc_addr = '0;
    bit            disc_m    = 1'b0;
    int            wait_cnt  = 0;
    int            ack_lat   = 1;
    int            ack_count = 0;
    int            n_chk     = 0;
    int            n_fail    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: consumer and arbiter act at the falling edge, caller resumes just after the rising edge.
    task automatic cyc();
        exp_t          e;
        logic [AW-1:0] cur;
        bit            ack_now;
        ack_now = 1'b0;
        @(negedge i_clk);
        if (i_rst && i_clk_en && o_inst_valid && i_inst_ready && !i_flush) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pop", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("inst_pc", o_inst_pc, e.pc);
                chk("inst", o_inst, e.inst);
            end
        end
        i_fetch_ack = 1'b0;
        if (i_rst && i_clk_en) begin
            if (o_fetch_read) begin
                if (wait_cnt >= ack_lat) begin
                    wait_cnt = 0;
                    ack_count++;
                    ack_now = 1'b1;
                    cur = disc_m ? disc_addr : exp_pc;
                    chk("fetch_addr", o_fetch_addr, cur);
                    i_fetch_data = {ack_count[15:0] ^ 16'hA5A5, cur[15:0]};
                    i_fetch_ack  = 1'b1;
                    if (!i_flush && !disc_m) begin
                        e.inst = i_fetch_data;
                        e.pc   = exp_pc;
                        sbq.push_back(e);
                        exp_pc = exp_pc + 32'd4;
                    end
                    disc_m = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            if (i_flush) begin
                if (o_fetch_read && !ack_now && !disc_m) begin
                    disc_m    = 1'b1;
                    disc_addr = exp_pc;
                end
                exp_pc = i_flush_pc & ~32'h3;
                sbq.delete();
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_fresh(input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (o_fetch_read && wait_cnt == 0) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        if (!found) chk(name, 0, 1);
    endtask

    task automatic drain();
        bit done;
        done    = 1'b0;
        i_stall = 1'b1;
        i_inst_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (!o_fetch_read && !o_inst_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, run aborted");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt[5];
        logic [AW-1:0] old;
        bit            saw_valid, found;
        int            tries;

        vt[0] = '{pc: 32'h0000_0100, lat: 3, flush_at: 1, exp_addr: 32'h0000_0100};
        vt[1] = '{pc: 32'h0000_0200, lat: 2, flush_at: 2, exp_addr: 32'h0000_0200};
        vt[2] = '{pc: 32'h0000_0302, lat: 1, flush_at: 0, exp_addr: 32'h0000_0300};
        vt[3] = '{pc: 32'hFFFF_FFFC, lat: 0, flush_at: 0, exp_addr: 32'hFFFF_FFFC};
        vt[4] = '{pc: 32'h0000_0040, lat: 4, flush_at: 3, exp_addr: 32'h0000_0040};

        // Reset values
        cyc();
        cyc();
        chk("rst_fetch_read", o_fetch_read, 0);
        chk("rst_fetch_addr", o_fetch_addr, 32'h0);
        chk("rst_inst_valid", o_inst_valid, 0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_inst_pc", o_inst_pc, 32'h0);

        // First request and first valid instruction timing, then streaming
        i_inst_ready = 1'b1;
        ack_lat = 1;
        i_rst = 1'b1;
        cyc();
        chk("first_read", o_fetch_read, 1);
        chk("first_addr", o_fetch_addr, 32'h0);
        cyc();
        chk("first_valid_early", o_inst_valid, 0);
        cyc();
        chk("first_valid", o_inst_valid, 1);
        chk("first_inst_pc", o_inst_pc, 32'h0);
        if (sbq.size() != 0) chk("first_inst", o_inst, sbq[0].inst);
        else chk("first_sbq", 0, 1);
        repeat (20) cyc();

        // Clock-enable freeze with two buffered entries and a fresh request outstanding
        i_inst_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sbq.size() == 2 && o_fetch_read && wait_cnt == 0) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk("freeze_setup", found, 1);
        i_clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("freeze_read", o_fetch_read, 1);
            chk("freeze_addr", o_fetch_addr, exp_pc);
            chk("freeze_valid", o_inst_valid, 1);
            if (sbq.size() != 0) begin
                chk("freeze_inst", o_inst, sbq[0].inst);
                chk("freeze_pc", o_inst_pc, sbq[0].pc);
            end
        end
        i_clk_en = 1'b1;
        i_inst_ready = 1'b1;
        repeat (12) cyc();

        // Asynchronous reset in the middle of a request
        ack_lat = 3;
        wait_fresh("rst_wait_timeout");
        #3;
        i_rst = 1'b0;
        #1;
        chk("arst_read", o_fetch_read, 0);
        chk("arst_valid", o_inst_valid, 0);
        sbq.delete();
        exp_pc = '0;
        disc_m = 1'b0;
        wait_cnt = 0;
        ack_count = 0;
        i_fetch_ack = 1'b0;
        cyc();
        i_inst_ready = 1'b0;
        ack_lat = 1;
        i_rst = 1'b1;
        cyc();
        chk("restart_read", o_fetch_read, 1);
        chk("restart_addr", o_fetch_addr, 32'h0);

        // Backpressure: exactly DEPTH acks, then no more requests
        repeat (30) cyc();
        chk("bp_ack_count", ack_count, DEPTH);
        chk("bp_read_idle", o_fetch_read, 0);
        chk("bp_valid", o_inst_valid, 1);
        chk("bp_sbq_size", sbq.size(), DEPTH);
        i_inst_ready = 1'b1;
        wait_fresh("bp_resume_timeout");
        chk("bp_resume_addr", o_fetch_addr, 32'h10);
        repeat (6) cyc();

        // Stall while idle
        drain();
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_no_read", o_fetch_read, 0);
        end

        // Redirect vectors
        i_stall = 1'b0;
        i_inst_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            ack_lat = vt[r].lat;
            wait_fresh("vec_wait_timeout");
            old = exp_pc;
            repeat (vt[r].flush_at) cyc();
            i_flush = 1'b1;
            i_flush_pc = vt[r].pc;
            cyc();
            i_flush = 1'b0;
            chk("flush_valid", o_inst_valid, 0);
            if (vt[r].flush_at < vt[r].lat) begin
                chk("held_read", o_fetch_read, 1);
                chk("held_addr", o_fetch_addr, old);
            end
            saw_valid = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (o_fetch_read && wait_cnt == 0) begin
                    found = 1'b1;
                    break;
                end
                saw_valid |= o_inst_valid;
                cyc();
            end
            chk("redirect_found", found, 1);
            chk("redirect_addr", o_fetch_addr, vt[r].exp_addr);
            chk("redirect_gap_valid", saw_valid, 0);
            repeat (4) cyc();
        end

        // Second flush while the first is still discarding
        ack_lat = 5;
        wait_fresh("dbl_wait_timeout");
        old = exp_pc;
        cyc();
        i_flush = 1'b1;
        i_flush_pc = 32'h0000_0500;
        cyc();
        i_flush = 1'b0;
        cyc();
        i_flush = 1'b1;
        i_flush_pc = 32'h0000_0600;
        cyc();
        i_flush = 1'b0;
        chk("dbl_held_read", o_fetch_read, 1);
        chk("dbl_held_addr", o_fetch_addr, old);
        tries = 0;
        while (!(o_fetch_read && wait_cnt == 0) && tries < 20) begin
            cyc();
            tries++;
        end
        chk("dbl_redirect_addr", o_fetch_addr, 32'h0000_0600);
        ack_lat = 1;
        repeat (8) cyc();

        // Flush while idle
        drain();
        i_flush = 1'b1;
        i_flush_pc = 32'h0000_0800;
        cyc();
        i_flush = 1'b0;
        chk("idle_flush_no_read", o_fetch_read, 0);
        i_stall = 1'b0;
        wait_fresh("idle_flush_timeout");
        chk("idle_flush_addr", o_fetch_addr, 32'h0000_0800);
        repeat (10) cyc();

        drain();
        chk("sbq_empty_at_end", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch stage between the memory arbiter's fetch read port and decode.
- Owns the fetch PC, runs one fetch read at a time on the arbiter port, and buffers returned words with their PCs in a small FIFO.
- Presents words to decode over a valid/ready handshake.
- Redirects (branch/jump/trap) flush the queue and restart fetching at a new PC.

Parameters:
- AW, 32, address width.
- DW, 32, data width; instructions are DW bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_clk_en  in  1  global clock enable; no state changes when low.
- i_stall  in  1  arbiter stall line; blocks issuing a new fetch request.
- i_flush  in  1  redirect request, single-cycle pulse.
- i_flush_pc  in  AW  redirect target.
- o_fetch_read  out  1  fetch read request to arbiter.
- o_fetch_addr  out  AW  fetch address.
- i_fetch_data  in  DW  read data, valid when i_fetch_ack=1.
- i_fetch_ack  in  1  read completion.
- o_inst  out  DW  head instruction.
- o_inst_pc  out  AW  PC of head instruction.
- o_inst_valid  out  1  head entry valid.
- i_inst_ready  in  1  decode accepts head.

Behaviour:
- Reset (i_rst=0, async):
  - fetch_pc=RESET_PC; FIFO empty; no request in flight; discard flag clear.
  - Outputs: o_fetch_read=0, o_fetch_addr=RESET_PC, o_inst_valid=0, o_inst=0, o_inst_pc=0.
- Gating: every register update is qualified by i_clk_en. When i_clk_en=0, outputs hold.
- Request issue:
  - When idle, i_stall=0, and (count + in_flight) < DEPTH, assert o_fetch_read with o_fetch_addr=fetch_pc on the next cycle.
  - Hold both stable until i_fetch_ack. At most one request is outstanding.
  - i_stall does not withdraw a request already asserted.
- Ack handling:
  - On i_fetch_ack with discard clear: push {i_fetch_data, fetch_pc} into the FIFO, set fetch_pc+=4 (mod 2^AW, wraps at top), and drop o_fetch_read that cycle.
  - A new request may assert the following cycle, giving at most one ack per 2 cycles.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare.
  - o_inst_valid = !empty; o_inst and o_inst_pc come from the head entry, combinationally from storage.
  - Pop on o_inst_valid & i_inst_ready.
  - Push and pop in the same cycle keeps count unchanged.
  - Credit rule guarantees no push when full.
- Flush (i_flush=1):
  - Next cycle: FIFO empty, o_inst_valid=0, fetch_pc=i_flush_pc.
  - A pop in the flush cycle is ignored.
  - If a request is outstanding and not acked this cycle, set discard. o_fetch_read stays high at the old address until ack. The acked data is dropped and discard clears; fetch then resumes from i_flush_pc.
  - Flush coincident with ack: the ack data is dropped; fetch_pc=i_flush_pc; no discard is set.
  - Flush while discard already set: discard stays set; fetch_pc updates to the newest i_flush_pc.
- States:
  - IDLE: no request.
  - REQ: o_fetch_read high.
  - DISCARD: o_fetch_read high, result to drop.
  - Transitions:
    - IDLE→REQ on credit & !i_stall & !i_flush.
    - REQ→IDLE on ack & !i_flush.
    - REQ→DISCARD on i_flush & !ack.
    - REQ→IDLE on i_flush & ack.
    - DISCARD→IDLE on ack.
- Latency: first instruction is valid 2 cycles after reset deassert plus arbiter ack latency, and 1 cycle after ack.

Optional Feature:
- Macro: PREFETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output o_inst_misalign (1 bit), stored per FIFO entry.
  - i_flush_pc[1:0]!=0 produces a single entry: o_inst=0, o_inst_pc=i_flush_pc, o_inst_misalign=1, pushed without issuing any fetch.
  - Fetching then halts (IDLE, no requests) until the next flush.
- Undefined:
  - Port absent.
  - i_flush_pc[1:0] is ignored and treated as 2'b00.

Test Plan:
- Reset release, arbiter acks 1 cycle after read, i_inst_ready=1 → o_fetch_addr sequence 0x0,0x4,0x8; o_inst_pc matches; o_inst equals acked data.
- i_inst_ready=0, DEPTH=4 → exactly 4 acks then o_fetch_read stays 0. Raise ready → pops 4 entries in order (PCs 0x0..0xC), then fetch resumes at 0x10.
- Flush to 0x100 while a request to 0x8 is outstanding, ack 3 cycles later → o_fetch_read held at 0x8 until ack; data dropped; next request at 0x100; o_inst_valid=0 in between.
- Flush and ack in the same cycle → data dropped; next request at i_flush_pc.
- i_stall=1 during idle → no new o_fetch_read. i_clk_en=0 for 5 cycles mid-stream → all outputs frozen, no lost or duplicated entries.
- Async i_rst low mid-request → o_fetch_read=0 and o_inst_valid=0 immediately; after release, fetch restarts at RESET_PC.
